// File: rtl/satd_block_sched.sv
// Block scheduler for the SATD datapath: splits a block into 8x8 passes, launches and fetches each pass, and accumulates the per-pass results.
// Optional macro SATD_SCHED_ROUND_EN selects a rounded half-sum result instead of the raw sum.
module satd_block_sched #(
    parameter int SW       = 16,
    parameter int WAIT_MAX = 31
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          blk16,
    input  logic [SW-1:0] satd_in,
    input  logic          satd_in_valid,
    output logic          dp_start,
    output logic          fetch_en,
    output logic [3:0]    row_addr,
    output logic [3:0]    col_base,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [SW+1:0] satd_total
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_FETCH,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          blk16_q, blk16_d;
    logic [SW+1:0] acc_q, acc_d;
    logic [1:0]    sub_idx_q, sub_idx_d;
    logic [2:0]    fcnt_q, fcnt_d;
    logic [4:0]    wait_cnt_q, wait_cnt_d;
    logic          err_q, err_d;
    logic [SW+1:0] satd_total_q, satd_total_d;

    logic          last_pass;
    logic          timeout_hit;
    logic [SW+1:0] final_acc;

    assign last_pass   = blk16_q ? (sub_idx_q == 2'd3) : 1'b1;
    assign timeout_hit = (wait_cnt_q == 5'(WAIT_MAX));

`ifdef SATD_SCHED_ROUND_EN
    // One extra bit keeps the +1 from wrapping before the halving shift.
    logic [SW+2:0] acc_plus_one;
    assign acc_plus_one = {1'b0, acc_q} + {{(SW+2){1'b0}}, 1'b1};
    assign final_acc    = acc_plus_one[SW+2:1];
`else
    assign final_acc = acc_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            blk16_q      <= 1'b0;
            acc_q        <= '0;
            sub_idx_q    <= '0;
            fcnt_q       <= '0;
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
            satd_total_q <= '0;
        end else begin
            state_q      <= state_d;
            blk16_q      <= blk16_d;
            acc_q        <= acc_d;
            sub_idx_q    <= sub_idx_d;
            fcnt_q       <= fcnt_d;
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
            satd_total_q <= satd_total_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_FETCH;
            S_FETCH:  if (fcnt_q == 3'd7) state_d = S_WAIT;
            S_WAIT: begin
                if (satd_in_valid)    state_d = S_NEXT;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_NEXT:   state_d = last_pass ? S_DONE : S_LAUNCH;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Counters free-run only in their own state so each entry starts from zero.
    always_comb begin
        blk16_d      = blk16_q;
        acc_d        = acc_q;
        sub_idx_d    = sub_idx_q;
        err_d        = err_q;
        satd_total_d = satd_total_q;
        fcnt_d       = (state_q == S_FETCH) ? fcnt_q + 3'd1 : 3'd0;
        wait_cnt_d   = (state_q == S_WAIT) ? wait_cnt_q + 5'd1 : 5'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    blk16_d   = blk16;
                    acc_d     = '0;
                    sub_idx_d = '0;
                    err_d     = 1'b0;
                end
            end
            S_WAIT: begin
                if (satd_in_valid) begin
                    acc_d = acc_q + {2'b00, satd_in};
                end else if (timeout_hit) begin
                    err_d        = 1'b1;
                    satd_total_d = '0;
                end
            end
            S_NEXT: begin
                if (last_pass) satd_total_d = final_acc;
                else           sub_idx_d    = sub_idx_q + 2'd1;
            end
            default: ;
        endcase
    end

    // Sub-block order is row-major over the 2x2 grid of 8x8 tiles.
    always_comb begin
        dp_start   = (state_q == S_LAUNCH);
        fetch_en   = (state_q == S_FETCH);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        err        = err_q;
        satd_total = satd_total_q;
        row_addr   = 4'd0;
        col_base   = 4'd0;
        if (state_q == S_LAUNCH || state_q == S_FETCH) begin
            row_addr = {sub_idx_q[1], fcnt_q};
            col_base = {sub_idx_q[0], 3'b000};
        end
    end

endmodule

// File: tb/tb_satd_block_sched.sv
// Scoreboard bench for satd_block_sched: stimulus queues expected launches, fetches and results; a monitor checks them.
module tb_satd_block_sched;

    localparam int SW       = 16;
    localparam int WAIT_MAX = 31;

    logic          clk;
    logic          reset;
    logic          start;
    logic          blk16;
    logic [SW-1:0] satd_in;
    logic          satd_in_valid;
    logic          dp_start;
    logic          fetch_en;
    logic [3:0]    row_addr;
    logic [3:0]    col_base;
    logic          busy;
    logic          done;
    logic          err;
    logic [SW+1:0] satd_total;

    satd_block_sched #(.SW(SW), .WAIT_MAX(WAIT_MAX)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .blk16         (blk16),
        .satd_in       (satd_in),
        .satd_in_valid (satd_in_valid),
        .dp_start      (dp_start),
        .fetch_en      (fetch_en),
        .row_addr      (row_addr),
        .col_base      (col_base),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .satd_total    (satd_total)
    );

    typedef struct {
        int            cyc;
        logic [SW+1:0] total;
        logic          err;
    } done_exp_t;

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
    } addr_exp_t;

    done_exp_t done_q[$];
    addr_exp_t launch_q[$];
    addr_exp_t fetch_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b1;
    bit prev_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_dp_start"}, dp_start, 0);
        checkOutput({tag, "_fetch_en"}, fetch_en, 0);
        checkOutput({tag, "_row_addr"}, row_addr, 0);
        checkOutput({tag, "_col_base"}, col_base, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
        checkOutput({tag, "_satd_total"}, satd_total, 0);
    endtask

    // Monitor: compares every launch, fetch and completion against the queued expectations.
    always @(negedge clk) begin : monitor
        addr_exp_t a;
        done_exp_t e;
        if (prev_done) checkOutput("busy_after_done", busy, 0);
        if (mon_en && dp_start) begin
            if (launch_q.size() == 0) checkOutput("launch_unexpected", 1, 0);
            else begin
                a = launch_q.pop_front();
                checkOutput("launch_row", row_addr, a.row);
                checkOutput("launch_col", col_base, a.col);
            end
        end
        if (mon_en && fetch_en) begin
            if (fetch_q.size() == 0) checkOutput("fetch_unexpected", 1, 0);
            else begin
                a = fetch_q.pop_front();
                checkOutput("fetch_row", row_addr, a.row);
                checkOutput("fetch_col", col_base, a.col);
            end
        end
        if (done) begin
            if (done_q.size() == 0) checkOutput("done_unexpected", 1, 0);
            else begin
                e = done_q.pop_front();
                checkOutput("done_cycle", cyc, e.cyc);
                checkOutput("satd_total", satd_total, e.total);
                checkOutput("err_at_done", err, e.err);
                checkOutput("busy_at_done", busy, 1);
            end
        end
        prev_done = done;
    end

    task automatic applyStimulus(input logic b16, input int gaps[4], input int vals[4],
                                 input bit timeout, input bit spur, input bit poke);
        int            t;
        int            npass;
        int            wv[4];
        logic [19:0]   sum;
        addr_exp_t     a;
        done_exp_t     e;
        @(posedge clk);
        #1;
        t     = cyc;
        start = 1'b1;
        blk16 = b16;
        npass = b16 ? 4 : 1;
        sum   = '0;
        for (int p = 0; p < npass; p++) begin
            a.row = 4'(8 * (p / 2));
            a.col = 4'(8 * (p % 2));
            launch_q.push_back(a);
            for (int f = 0; f < 8; f++) begin
                a.row = 4'(8 * (p / 2) + f);
                fetch_q.push_back(a);
            end
            wv[p] = (p == 0) ? t + 10 : wv[p-1] + gaps[p-1] + 11;
            sum   = sum + 20'(vals[p]);
        end
        if (timeout) begin
            e.cyc   = t + 10 + WAIT_MAX + 1;
            e.total = '0;
            e.err   = 1'b1;
        end else begin
            e.cyc = wv[npass-1] + gaps[npass-1] + 2;
`ifdef SATD_SCHED_ROUND_EN
            e.total = 18'((sum + 20'd1) >> 1);
`else
            e.total = 18'(sum);
`endif
            e.err = 1'b0;
        end
        done_q.push_back(e);

        wait_cycle(t + 1);
        start = 1'b0;
        checkOutput("busy_rise", busy, 1);
        checkOutput("err_clear_on_start", err, 0);
        if (spur) begin
            satd_in_valid = 1'b1;
            satd_in       = 16'd999;
        end
        fork
            begin
                if (timeout) begin
                    wait_cycle(t + 10);
                    satd_in_valid = 1'b0;
                    satd_in       = '0;
                end else begin
                    for (int p = 0; p < npass; p++) begin
                        wait_cycle(wv[p] + gaps[p]);
                        satd_in_valid = 1'b1;
                        satd_in       = 16'(vals[p]);
                        wait_cycle(wv[p] + gaps[p] + 1);
                        satd_in_valid = 1'b0;
                        satd_in       = '0;
                    end
                end
            end
            begin
                if (poke) begin
                    wait_cycle(t + 5);
                    start = 1'b1;
                    blk16 = ~b16;
                    wait_cycle(t + 6);
                    start = 1'b0;
                    blk16 = b16;
                    wait_cycle(t + 12);
                    start = 1'b1;
                    blk16 = ~b16;
                    wait_cycle(t + 13);
                    start = 1'b0;
                    blk16 = b16;
                end
            end
        join
        for (int i = 0; i < 100 && done_q.size() != 0; i++) @(posedge clk);
        if (done_q.size() != 0) begin
            checkOutput("done_missing", done_q.size(), 0);
            done_q.delete();
        end
        checkOutput("launch_left", launch_q.size(), 0);
        checkOutput("fetch_left", fetch_q.size(), 0);
        launch_q.delete();
        fetch_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        int g[4];
        int v[4];
        int t;
        reset         = 1'b1;
        start         = 1'b0;
        blk16         = 1'b0;
        satd_in       = '0;
        satd_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] 8x8 single pass, value 100");
        g = '{0, 0, 0, 0};
        v = '{100, 0, 0, 0};
        applyStimulus(1'b0, g, v, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset during FETCH of a 16x16 block");
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        t     = cyc;
        start = 1'b1;
        blk16 = 1'b1;
        wait_cycle(t + 1);
        start = 1'b0;
        wait_cycle(t + 5);
        checkOutput("midfetch_fetch_en", fetch_en, 1);
        reset = 1'b1;
        wait_cycle(t + 6);
        checkIdleOutputs("abort");
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (50) @(posedge clk);
        #1;

        $display("[TB] 16x16 with gaps, values 10/20/30/41");
        g = '{0, 1, 3, 2};
        v = '{10, 20, 30, 41};
        applyStimulus(1'b1, g, v, 1'b0, 1'b0, 1'b0);

        $display("[TB] 8x8 timeout");
        g = '{0, 0, 0, 0};
        v = '{0, 0, 0, 0};
        applyStimulus(1'b0, g, v, 1'b1, 1'b0, 1'b0);
        checkOutput("err_held", err, 1);
        checkOutput("timeout_total_held", satd_total, 0);

        $display("[TB] spurious valid before WAIT, then 7");
        g = '{0, 0, 0, 0};
        v = '{7, 0, 0, 0};
        applyStimulus(1'b0, g, v, 1'b0, 1'b1, 1'b0);

        $display("[TB] 16x16 max values with start pulses while busy");
        g = '{0, 0, 0, 0};
        v = '{65535, 65535, 65535, 65535};
        applyStimulus(1'b1, g, v, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/satd_block_sched.md
# satd_block_sched

Block-level scheduler for the SATD datapath. It accepts a block request, splits a 16x16 block into four 8x8 sub-blocks (an 8x8 request is a single pass), and for each pass issues a launch pulse and 8 row fetches. It then waits for the per-pass SATD result and accumulates a block total. It sits between the motion-search front end and the staged Hadamard/SATD datapath, and reports done/error to the requester.

## Interface
- SW, 16, width of per-pass SATD result from datapath
- WAIT_MAX, 31, max cycles spent in WAIT before timeout (5-bit counter)
- clk  in  1  clock; reset reset, synchronous, active-high; clock clk
- reset  in  1  synchronous active-high reset
- start  in  1  block request; accepted only in IDLE
- blk16  in  1  sampled with start: 1 = 16x16 (4 passes), 0 = 8x8 (1 pass)
- satd_in  in  SW  per-pass SATD from datapath
- satd_in_valid  in  1  satd_in qualifier; honoured only in WAIT
- dp_start  out  1  one-cycle datapath launch pulse per pass
- fetch_en  out  1  row fetch strobe
- row_addr  out  4  source row (0..15)
- col_base  out  4  source column base (0 or 8)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  timeout flag, held until next accepted start
- satd_total  out  SW+2  block result, held until next done

## Operation
- States: IDLE, LAUNCH, FETCH, WAIT, NEXT, DONE.
- IDLE: start=1 latches blk16, clears acc, sub_idx, err, and goes to LAUNCH. start is ignored in all other states.
- LAUNCH (1 cycle): dp_start=1. Drives row_addr/col_base for the pass. Goes to FETCH.
- FETCH (8 cycles): fetch_en=1. row_addr = 8*sub_idx[1] + fcnt, fcnt 0..7. col_base = 8*sub_idx[0]. When fcnt=7, goes to WAIT.
- WAIT: wait_cnt starts at 0 and increments each cycle.
  - If satd_in_valid: acc <= acc + satd_in (zero-extended) and go to NEXT.
  - If no valid and wait_cnt==WAIT_MAX: err<=1, satd_total<=0, go to DONE.
  - Valid takes priority over timeout in the same cycle.
- NEXT (1 cycle):
  - If last pass (sub_idx==3 for 16x16, 0 for 8x8): satd_total <= final(acc), go to DONE.
  - Otherwise sub_idx++ and go to LAUNCH.
- Sub-block order: 0=(r0,c0), 1=(r0,c8), 2=(r8,c0), 3=(r8,c8).
- DONE (1 cycle): done=1, then IDLE.
- acc is SW+2 bits. 4 x (2^SW - 1) cannot overflow, so no saturation logic is needed.
- satd_in_valid outside WAIT is ignored and never accumulated.

## Timing
- Reset values: IDLE, and all outputs 0 (dp_start, fetch_en, row_addr, col_base, busy, done, err, satd_total). Internal acc, sub_idx, fcnt and wait_cnt are also 0.
- Reset has priority over everything. A reset asserted mid-block aborts the block with no done pulse.
- All outputs are registered or decoded from state, with no combinational path from inputs.
- Per pass: LAUNCH 1 cycle + FETCH 8 cycles + WAIT ≥1 cycle + NEXT 1 cycle.
- 8x8 minimum: start sampled at cycle T; LAUNCH at T+1; FETCH T+2..T+9; WAIT at T+10 with valid; NEXT at T+11; done=1 at T+12.
- 16x16 minimum: done at T+45.
- busy rises at T+1 and falls on the cycle after done.
- start held high through DONE begins a new block on the IDLE cycle after DONE; there is no back-to-back restart out of DONE.

## Configuration
- SATD_SCHED_ROUND_EN defined: final(acc) = (acc + 1) >> 1, the Hadamard normalisation applied here.
- Not defined: final(acc) = acc, raw sum.
- The timeout result of 0 is unaffected by the macro.

## Test plan
- Reset mid-FETCH of a 16x16 block: busy=0 and all outputs 0 on the next cycle, no done; a following start runs normally.
- 8x8, start at T, satd_in=100 valid at first WAIT cycle: done at T+12, satd_total=100 (50 with SATD_SCHED_ROUND_EN), err=0.
- 16x16, valids 10, 20, 30, 41 with 0-3 cycle gaps: row_addr/col_base sequences match the order; four dp_start pulses; satd_total=101 (51 rounded).
- Timeout: 8x8 with no valid: done exactly WAIT_MAX+1 cycles after WAIT entry; err=1, satd_total=0; err clears on next accepted start.
- Spurious satd_in_valid=1 during LAUNCH/FETCH with satd_in=999, then a real 7 in WAIT: total=7.
- start pulsed while busy: ignored, with no effect on sequence or result.
